hazard_stall_controller: RTL and testbench

- Sequencing controller for the 5-stage pipeline; works beside the EX-stage forwarding unit.
- Resolves the hazards that forwarding cannot cover:
  - load-use, by a one-cycle stall plus bubble;
  - multi-cycle MUL/DIV occupancy of HI/LO, by a busy counter that stalls only dependent instructions;
  - taken-branch, by flushing the wrong-path instruction.
- Drives the PC, IF/ID and ID/EX write/flush controls and keeps a stall-cycle performance counter.

---
 rtl/hazard_stall_controller.sv | 92 +++++++++
 tb/tb_hazard_stall_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use and HI/LO-busy stalls, taken-branch
// flush, and a saturating stall-cycle performance counter.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_uses_hilo,
  input  logic             id_is_muldiv,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_muldiv_start,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MULDIV} state_t;

  localparam logic [7:0]       BUSY_LOAD = 8'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  logic [7:0] busy_cnt;
  logic       lu, hd, stall;

  always_comb begin
    lu    = ex_memread && (ex_rt != 5'd0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    hd    = (state == MULDIV) && (id_uses_hilo || id_is_muldiv);
    stall = (lu || hd) && !branch_taken;
  end

  // Outputs are Mealy, but held at their safe values while reset is asserted so
  // the pipeline registers are frozen/flushed without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    muldiv_busy  = 1'b0;
    if (rst_n) begin
      pc_write     = !stall;
      if_id_write  = !stall;
      if_id_flush  = branch_taken;
      id_ex_bubble = stall || branch_taken;
      muldiv_busy  = (state == MULDIV);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, and all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      busy_cnt <= 8'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_muldiv_start) begin
            state    <= MULDIV;
            busy_cnt <= BUSY_LOAD;
          end
        end
        MULDIV: begin
          // A second start while busy is illegal and deliberately ignored.
          if (busy_cnt == 8'd0) state <= RUN;
          else                  busy_cnt <= busy_cnt - 8'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_stall_controller;

  localparam int LAT = 4;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_uses_hilo, id_is_muldiv, ex_memread, ex_muldiv_start, branch_taken;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_busy;
  logic [W-1:0] stall_cycles;
  logic s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_muldiv_busy;
  logic [3:0] s_stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .id_is_muldiv(id_is_muldiv), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_muldiv_start(ex_muldiv_start), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  hazard_stall_controller #(.MULDIV_LAT(20), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .id_is_muldiv(id_is_muldiv), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_muldiv_start(ex_muldiv_start), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .muldiv_busy(s_muldiv_busy), .stall_cycles(s_stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles and an unbounded stall tally.
  int m_rem;
  int m_stalls;
  logic m_lu, m_stall;
  logic e_pc, e_flush, e_bubble, e_busy;

  always_comb begin
    m_lu    = ex_memread && (ex_rt != 0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    m_stall = (m_lu || ((m_rem > 0) && (id_uses_hilo || id_is_muldiv))) && !branch_taken;
    if (!rst_n) begin
      e_pc = 0; e_flush = 1; e_bubble = 1; e_busy = 0;
    end else begin
      e_pc = !m_stall; e_flush = branch_taken; e_bubble = m_stall || branch_taken;
      e_busy = (m_rem > 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem    <= 0;
      m_stalls <= 0;
    end else begin
      if (m_rem == 0 && ex_muldiv_start) m_rem <= LAT;
      else if (m_rem > 0)                m_rem <= m_rem - 1;
      if (m_stall) m_stalls <= (m_stalls >= (1 << W) - 1) ? (1 << W) - 1 : m_stalls + 1;
    end
  end

  always @(negedge clk) begin
    check("model_pc_write", pc_write, e_pc);
    check("model_if_id_write", if_id_write, e_pc);
    check("model_if_id_flush", if_id_flush, e_flush);
    check("model_id_ex_bubble", id_ex_bubble, e_bubble);
    check("model_muldiv_busy", muldiv_busy, e_busy);
    check("model_stall_cycles", stall_cycles, m_stalls);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
    id_uses_rt = 0; id_uses_hilo = 0; id_is_muldiv = 0;
    ex_memread = 0; ex_muldiv_start = 0; branch_taken = 0;
  endtask

  initial begin
    int busy_n, stall_n;
    rst_n = 0;
    idle();
    #2;
    check("reset_pc_write", pc_write, 0);
    check("reset_if_id_write", if_id_write, 0);
    check("reset_if_id_flush", if_id_flush, 1);
    check("reset_id_ex_bubble", id_ex_bubble, 1);
    check("reset_muldiv_busy", muldiv_busy, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    @(posedge clk);
    #2 rst_n = 1;

    // Load-use: one stall cycle, then release.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    next();
    ex_memread = 0;
    @(negedge clk);
    check("lu_after_pc_write", pc_write, 1);
    check("lu_after_bubble", id_ex_bubble, 0);
    check("lu_stall_cycles", stall_cycles, 1);

    // No false stall on r0, nor on rt when rt is not a source.
    next();
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    check("r0_no_stall", pc_write, 1);
    next();
    ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 0; id_rs = 5'd1;
    @(negedge clk);
    check("rt_unused_no_stall", pc_write, 1);
    next();
    id_uses_rt = 1;
    @(negedge clk);
    check("rt_used_stall", pc_write, 0);

    // MUL/DIV with independent instructions: busy 4 cycles, no stalls.
    next();
    idle(); ex_muldiv_start = 1;
    @(negedge clk);
    check("md_start_not_busy", muldiv_busy, 0);
    next();
    ex_muldiv_start = 0;
    busy_n = 0; stall_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (muldiv_busy) busy_n++;
      if (!pc_write) stall_n++;
      next();
    end
    check("md_busy_len", busy_n, 4);
    check("md_indep_stalls", stall_n, 0);

    // MUL/DIV with dependent MFHI held: stall for the busy window only.
    id_uses_hilo = 1; ex_muldiv_start = 1;
    @(negedge clk);
    check("md_dep_start_pc", pc_write, 1);
    next();
    ex_muldiv_start = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("md_dep_busy", muldiv_busy, 1);
      check("md_dep_pc", pc_write, 0);
      next();
    end
    @(negedge clk);
    check("md_dep_release_pc", pc_write, 1);
    check("md_dep_busy_drop", muldiv_busy, 0);
    check("md_dep_stall_cycles", stall_cycles, 6);
    next();

    // Branch overrides a load-use stall.
    idle(); ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1;
    @(negedge clk);
    check("br_pc_write", pc_write, 1);
    check("br_flush", if_id_flush, 1);
    check("br_bubble", id_ex_bubble, 1);
    next();
    idle();
    @(negedge clk);
    check("br_stall_unchanged", stall_cycles, 6);

    // Branch during MULDIV: flush happens, busy still ends on schedule.
    ex_muldiv_start = 1;
    next();
    ex_muldiv_start = 0; branch_taken = 1; id_uses_hilo = 1;
    @(negedge clk);
    check("br_md_flush", if_id_flush, 1);
    check("br_md_pc", pc_write, 1);
    check("br_md_busy", muldiv_busy, 1);
    next();
    idle();
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (muldiv_busy) busy_n++;
      next();
    end
    check("br_md_busy_rest", busy_n, 3);

    // Asynchronous reset in the middle of a MUL/DIV.
    ex_muldiv_start = 1;
    next();
    ex_muldiv_start = 0; id_uses_hilo = 1;
    next();
    #1 rst_n = 0;
    #1;
    check("arst_busy", muldiv_busy, 0);
    check("arst_stall_cycles", stall_cycles, 0);
    check("arst_pc_write", pc_write, 0);
    check("arst_if_id_write", if_id_write, 0);
    check("arst_flush", if_id_flush, 1);
    check("arst_bubble", id_ex_bubble, 1);
    @(posedge clk);
    #2 rst_n = 1;

    // Saturation on the narrow-counter instance.
    idle(); id_uses_hilo = 1; ex_muldiv_start = 1;
    next();
    ex_muldiv_start = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 10) check("sat_mid", s_stall_cycles, 10);
      if (i == 19) check("sat_hold", s_stall_cycles, 15);
      if (i == 22) check("sat_final", s_stall_cycles, 15);
      next();
    end

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      id_uses_hilo    = ($urandom_range(0, 9) < 3);
      id_is_muldiv    = ($urandom_range(0, 9) < 2);
      ex_memread      = ($urandom_range(0, 1) == 1);
      ex_muldiv_start = ($urandom_range(0, 9) < 2);
      branch_taken    = ($urandom_range(0, 19) < 3);
      next();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
